sum_stream_src: RTL

SUM_STREAM_SRC -- requirements
Module: sum_stream_src

---
 rtl/sum_stream_pkg.sv | 16 +
 rtl/sum_stream_buf.sv | 35 +++
 rtl/sum_stream_src.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sum_stream_pkg.sv
// Shared defaults and state encoding for the summing stream source.
package sum_stream_pkg;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_SEND,
    ST_TERM,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/sum_stream_buf.sv
// Word buffer with fill count; written in order, read combinationally by index.
module sum_stream_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH + 1),
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage needs no reset; only the count defines which entries are live.
  always_ff @(posedge ck) begin
    if (we) mem[count[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge ck) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (we)  count <= count + CW'(1);
  end

  assign rd_data = mem[rd_idx];
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/sum_stream_src.sv
// Streams buffered words to an external accumulator and checks its returned sum.
//
// state | meaning
// IDLE  | accepting writes/clr, waiting for start
// GO    | go_l strobe low for one cycle
// SEND  | one buffered word per cycle on outA
// TERM  | zero terminator word
// WAIT  | waiting for done, bounded by TIMEOUT
module sum_stream_src
  import sum_stream_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr,
  input  logic             start,
  input  logic             done,
  input  logic [WIDTH-1:0] sum,
  output logic             go_l,
  output logic [WIDTH-1:0] outA,
  output logic             busy,
  output logic             full,
  output logic             wr_err,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             match,
  output logic             timeout
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state, nstate;
  logic [CW-1:0]    count, len, idx;
  logic [TW-1:0]    wait_cnt;
  logic [WIDTH-1:0] expected, rd_data;
  logic             idle, wr_ok, wr_rej, clr_ok, start_ok;

  assign idle     = (state == ST_IDLE);
  assign clr_ok   = clr && idle;
  assign start_ok = start && !clr && idle;
  assign wr_ok    = wr_en && idle && (wr_data != '0) && !full && !clr && !start;
  // Writes coinciding with clr or start are dropped without an error.
  assign wr_rej   = wr_en && !wr_ok && !clr && !start;
  assign busy     = !idle;

  sum_stream_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW), .IW(IW)) u_buf (
    .ck      (ck),
    .reset   (reset),
    .we      (wr_ok),
    .wr_data (wr_data),
    .clr     (clr_ok),
    .rd_idx  (idx[IW-1:0]),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  always_comb begin
    nstate = state;
    go_l   = 1'b1;
    outA   = '0;
    case (state)
      ST_IDLE: if (start_ok) nstate = ST_GO;
      ST_GO: begin
        go_l   = 1'b0;
        nstate = (len != '0) ? ST_SEND : ST_TERM;
      end
      ST_SEND: begin
        outA = rd_data;
        if (idx == len - CW'(1)) nstate = ST_TERM;
      end
      ST_TERM: nstate = ST_WAIT;
      ST_WAIT: if (done || wait_cnt == '0) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state        <= ST_IDLE;
      len          <= '0;
      idx          <= '0;
      wait_cnt     <= '0;
      expected     <= '0;
      wr_err       <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      match        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= nstate;
      wr_err       <= wr_rej;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: if (start_ok) begin
          len      <= count;
          idx      <= '0;
          expected <= '0;
        end
        ST_SEND: begin
          expected <= expected + rd_data;
          idx      <= idx + CW'(1);
        end
        ST_TERM: wait_cnt <= TW'(TIMEOUT - 1);
        ST_WAIT: begin
          if (done) begin
            result_valid <= 1'b1;
            result       <= sum;
            match        <= (sum == expected);
            timeout      <= 1'b0;
          end else if (wait_cnt == '0) begin
            result_valid <= 1'b1;
            result       <= '0;
            match        <= 1'b0;
            timeout      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
